// File: rtl/parking_slot_manager_pkg.sv
// Shared constants, FSM state encoding and bitmap helpers for the parking slot manager.
// Bitmap convention: bit (NUM_SLOTS-1-i) set means slot i is free.
package parking_slot_manager_pkg;

    localparam int NUM_SLOTS  = 8;
    localparam int SLOT_IDX_W = 3;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t GATE = 1'b1;

    // Lowest free slot index; slot i lives at bit (NUM_SLOTS-1-i), so this is an MSB-first scan.
    function automatic logic [SLOT_IDX_W-1:0] first_free(input logic [NUM_SLOTS-1:0] bitmap);
        logic [SLOT_IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (bitmap[NUM_SLOTS-1-i]) idx = SLOT_IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] count_ones(input logic [NUM_SLOTS-1:0] bitmap);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cnt = cnt + 4'(bitmap[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/parking_slot_manager_gate_timer.sv
// Entry-barrier down-counter: loads GATE_CYCLES on start, active while non-zero,
// done flags the last active cycle so the FSM can leave GATE at the following edge.
module gate_timer #(
    parameter int GATE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic active,
    output logic done
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= 4'(GATE_CYCLES);
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign active = (cnt != 4'd0);
    assign done   = (cnt == 4'd1);

endmodule

// File: rtl/parking_slot_manager.sv
// Parking slot manager: free-slot bitmap, lowest-index slot grant, exit handling
// and an IDLE/GATE FSM that holds the entry barrier open via gate_timer.
// Handshake: entry_req is level, held by the requester until entry_ack or entry_nack
// (each a one-cycle pulse); exit_req is a one-cycle pulse qualifying exit_slot.
module parking_slot_manager
    import parking_slot_manager_pkg::*;
#(
    parameter int GATE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  entry_req,
    input  logic                  exit_req,
    input  logic [SLOT_IDX_W-1:0] exit_slot,
    output logic [NUM_SLOTS-1:0]  parking_capacity,
    output logic [3:0]            free_count,
    output logic                  parking_full,
    output logic                  entry_ack,
    output logic                  entry_nack,
    output logic [SLOT_IDX_W-1:0] assigned_slot,
    output logic                  gate_open,
    output logic                  exit_err,
    output state_t                state_dbg
);

    state_t                state;
    logic                  grant;
    logic                  refuse;
    logic                  exit_dup;
    logic                  timer_done;
    logic [SLOT_IDX_W-1:0] grant_slot;
    logic [SLOT_IDX_W-1:0] exit_bit;
    logic [SLOT_IDX_W-1:0] grant_bit;
    logic [NUM_SLOTS-1:0]  cap_next;

    assign free_count   = count_ones(parking_capacity);
    assign parking_full = (parking_capacity == '0);
    assign state_dbg    = state;

    always_comb begin
        grant      = (state == IDLE) && entry_req && !parking_full;
        // A held request must not draw a second nack right after the first one.
        refuse     = (state == IDLE) && entry_req && parking_full && !entry_nack;
        grant_slot = first_free(parking_capacity);
        grant_bit  = SLOT_IDX_W'(NUM_SLOTS - 1) - grant_slot;
        exit_bit   = SLOT_IDX_W'(NUM_SLOTS - 1) - exit_slot;
        exit_dup   = exit_req && parking_capacity[exit_bit];
        cap_next   = parking_capacity;
        if (exit_req && !parking_capacity[exit_bit]) cap_next[exit_bit] = 1'b1;
        // Grant is applied last so it wins over an exit naming the same slot.
        if (grant) cap_next[grant_bit] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            parking_capacity <= '1;
            assigned_slot    <= '0;
            entry_ack        <= 1'b0;
            entry_nack       <= 1'b0;
            exit_err         <= 1'b0;
        end else begin
            parking_capacity <= cap_next;
            entry_ack        <= grant;
            entry_nack       <= refuse;
            exit_err         <= exit_dup;
            if (grant) assigned_slot <= grant_slot;
            case (state)
                IDLE:    if (grant) state <= GATE;
                GATE:    if (timer_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    gate_timer #(.GATE_CYCLES(GATE_CYCLES)) u_gate_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (grant),
        .active (gate_open),
        .done   (timer_done)
    );

endmodule

// File: tb/tb_parking_slot_manager.sv
// Directed bench for parking_slot_manager: one task per scenario, inline checks,
// one summary line at the end.
module tb_parking_slot_manager;
    import parking_slot_manager_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [2:0] exit_slot = 3'd0;
    logic [7:0] parking_capacity;
    logic [3:0] free_count;
    logic       parking_full;
    logic       entry_ack;
    logic       entry_nack;
    logic [2:0] assigned_slot;
    logic       gate_open;
    logic       exit_err;
    state_t     state_dbg;

    int checks = 0;
    int passed = 0;

    parking_slot_manager #(.GATE_CYCLES(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .entry_req        (entry_req),
        .exit_req         (exit_req),
        .exit_slot        (exit_slot),
        .parking_capacity (parking_capacity),
        .free_count       (free_count),
        .parking_full     (parking_full),
        .entry_ack        (entry_ack),
        .entry_nack       (entry_nack),
        .assigned_slot    (assigned_slot),
        .gate_open        (gate_open),
        .exit_err         (exit_err),
        .state_dbg        (state_dbg)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it, inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; exit_slot = 3'd0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (parking_capacity !== 8'hFF) $display("FAIL reset_cap actual=%h expected=ff", parking_capacity); else passed++;
        checks++; if (free_count !== 4'd8) $display("FAIL reset_free actual=%0d expected=8", free_count); else passed++;
        checks++; if ({parking_full, entry_ack, entry_nack, exit_err, gate_open} !== 5'b0)
            $display("FAIL reset_flags actual=%b expected=00000", {parking_full, entry_ack, entry_nack, exit_err, gate_open}); else passed++;
        checks++; if (assigned_slot !== 3'd0) $display("FAIL reset_slot actual=%0d expected=0", assigned_slot); else passed++;
        checks++; if (state_dbg !== IDLE) $display("FAIL reset_state actual=%0d expected=0", state_dbg); else passed++;
    endtask

    task automatic test_first_grant();
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        checks++; if (entry_ack !== 1'b1) $display("FAIL first_ack actual=%b expected=1", entry_ack); else passed++;
        checks++; if (assigned_slot !== 3'd0) $display("FAIL first_slot actual=%0d expected=0", assigned_slot); else passed++;
        checks++; if (parking_capacity !== 8'h7F) $display("FAIL first_cap actual=%h expected=7f", parking_capacity); else passed++;
        checks++; if (free_count !== 4'd7) $display("FAIL first_free actual=%0d expected=7", free_count); else passed++;
        checks++; if (gate_open !== 1'b1 || state_dbg !== GATE) $display("FAIL first_gate actual=%b%b expected=11", gate_open, state_dbg); else passed++;
        for (int c = 2; c <= 4; c++) begin
            tick();
            checks++; if (gate_open !== 1'b1 || entry_ack !== 1'b0)
                $display("FAIL first_gate_c%0d actual=%b%b expected=10", c, gate_open, entry_ack); else passed++;
        end
        tick();
        checks++; if (gate_open !== 1'b0 || state_dbg !== IDLE) $display("FAIL first_gate_end actual=%b%b expected=00", gate_open, state_dbg); else passed++;
    endtask

    // Grants one slot and returns to IDLE (four more edges after the grant edge).
    task automatic grant_one(input logic [2:0] exp_slot, input logic [7:0] exp_cap, input string tag);
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        checks++; if (entry_ack !== 1'b1 || assigned_slot !== exp_slot || parking_capacity !== exp_cap)
            $display("FAIL %s actual=ack%b slot%0d cap%h expected=ack1 slot%0d cap%h", tag, entry_ack, assigned_slot, parking_capacity, exp_slot, exp_cap);
        else passed++;
        repeat (4) tick();
    endtask

    task automatic test_fill();
        for (int k = 1; k < 8; k++) begin
            logic [7:0] exp_cap;
            exp_cap = 8'hFF >> (k + 1);
            grant_one(3'(k), exp_cap, $sformatf("fill_%0d", k));
        end
        checks++; if (parking_full !== 1'b1 || free_count !== 4'd0) $display("FAIL fill_full actual=%b/%0d expected=1/0", parking_full, free_count); else passed++;
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        checks++; if (entry_nack !== 1'b1 || entry_ack !== 1'b0 || gate_open !== 1'b0)
            $display("FAIL nack actual=nack%b ack%b gate%b expected=nack1 ack0 gate0", entry_nack, entry_ack, gate_open); else passed++;
        tick();
        checks++; if (entry_nack !== 1'b0 || gate_open !== 1'b0 || parking_capacity !== 8'h00)
            $display("FAIL nack_after actual=nack%b gate%b cap%h expected=nack0 gate0 cap00", entry_nack, gate_open, parking_capacity); else passed++;
    endtask

    task automatic test_exit_regrant();
        exit_req = 1'b1; exit_slot = 3'd2;
        tick();
        exit_req = 1'b0;
        checks++; if (parking_capacity !== 8'h20 || exit_err !== 1'b0 || free_count !== 4'd1)
            $display("FAIL exit2 actual=cap%h err%b free%0d expected=cap20 err0 free1", parking_capacity, exit_err, free_count); else passed++;
        grant_one(3'd2, 8'h00, "regrant2");
    endtask

    task automatic test_exit_err();
        do_reset();
        exit_req = 1'b1; exit_slot = 3'd5;
        tick();
        exit_req = 1'b0;
        checks++; if (exit_err !== 1'b1 || parking_capacity !== 8'hFF)
            $display("FAIL exit_err actual=err%b cap%h expected=err1 capff", exit_err, parking_capacity); else passed++;
        tick();
        checks++; if (exit_err !== 1'b0) $display("FAIL exit_err_pulse actual=%b expected=0", exit_err); else passed++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int k = 0; k < 7; k++) grant_one(3'(k), 8'hFF >> (k + 1), $sformatf("pre_%0d", k));
        checks++; if (parking_capacity !== 8'h01) $display("FAIL sim_pre actual=%h expected=01", parking_capacity); else passed++;
        entry_req = 1'b1; exit_req = 1'b1; exit_slot = 3'd0;
        tick();
        entry_req = 1'b0; exit_req = 1'b0;
        checks++; if (entry_ack !== 1'b1 || assigned_slot !== 3'd7 || parking_capacity !== 8'h80 || exit_err !== 1'b0)
            $display("FAIL sim_grant_exit actual=ack%b slot%0d cap%h err%b expected=ack1 slot7 cap80 err0",
                     entry_ack, assigned_slot, parking_capacity, exit_err); else passed++;
        repeat (4) tick();
    endtask

    task automatic test_grant_wins();
        do_reset();
        entry_req = 1'b1; exit_req = 1'b1; exit_slot = 3'd0;
        tick();
        entry_req = 1'b0; exit_req = 1'b0;
        checks++; if (entry_ack !== 1'b1 || assigned_slot !== 3'd0 || parking_capacity !== 8'h7F || exit_err !== 1'b1)
            $display("FAIL grant_wins actual=ack%b slot%0d cap%h err%b expected=ack1 slot0 cap7f err1",
                     entry_ack, assigned_slot, parking_capacity, exit_err); else passed++;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid_gate();
        do_reset();
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        tick();
        checks++; if (gate_open !== 1'b1 || parking_capacity !== 8'h7F) $display("FAIL mid_pre actual=gate%b cap%h expected=gate1 cap7f", gate_open, parking_capacity); else passed++;
        reset = 1'b1; entry_req = 1'b1; exit_req = 1'b1; exit_slot = 3'd3;
        tick();
        reset = 1'b0; entry_req = 1'b0; exit_req = 1'b0;
        checks++; if (gate_open !== 1'b0 || parking_capacity !== 8'hFF || state_dbg !== IDLE || entry_ack !== 1'b0 || exit_err !== 1'b0)
            $display("FAIL mid_reset actual=gate%b cap%h st%0d ack%b err%b expected=gate0 capff st0 ack0 err0",
                     gate_open, parking_capacity, state_dbg, entry_ack, exit_err); else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_grant();
        test_fill();
        test_exit_regrant();
        test_exit_err();
        test_simultaneous();
        test_grant_wins();
        test_reset_mid_gate();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
